// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the IF and MEM ports. Data accesses take priority, and the stall is held until every pending request is served.
// Optional bus watchdog: define MEMARB_TIMEOUT_EN. The limit is set by TIMEOUT.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_inst_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_o,
  output logic        bus_cyc_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, DATA, INST} state_e;

  typedef struct packed {
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  state_e      state_q, state_d;
  bus_t        bus_q, bus_d;
  bus_t        data_req, inst_req;
  logic        data_done_q, data_done_d;
  logic        inst_done_q, inst_done_d;
  logic        discard_q, discard_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [31:0] inst_q, inst_d;

  logic        busy, timeout, ack, discard;
  logic        data_ack, inst_ack, data_pend, inst_pend;
  logic [31:0] rdata;

  assign busy     = (state_q != IDLE);
  assign ack      = busy & (bus_ack_i | timeout);
  assign rdata    = bus_ack_i ? bus_rdata_i : 32'h0;
  assign discard  = discard_q | flush_i;
  // A flushed cycle's ack leaves its request pending.
  assign data_ack = (state_q == DATA) & ack & ~discard;
  assign inst_ack = (state_q == INST) & ack & ~discard;

  assign data_pend = mem_ce_i & ~data_done_q;
  assign inst_pend = if_ce_i & ~inst_done_q;

  assign stallreq_o = ~rst & ~flush_i &
                      ((data_pend & ~data_ack) | (inst_pend & ~inst_ack));

  assign mem_data_o = data_ack ? rdata : mem_rdata_q;
  assign if_inst_o  = inst_ack ? rdata : inst_q;

  assign data_req = '{cyc: 1'b1, we: mem_we_i, sel: mem_sel_i,
                      addr: mem_addr_i, wdata: mem_data_i};
  assign inst_req = '{cyc: 1'b1, we: 1'b0, sel: 4'hf,
                      addr: if_addr_i, wdata: 32'h0};

  assign bus_cyc_o   = bus_q.cyc;
  assign bus_we_o    = bus_q.we;
  assign bus_sel_o   = bus_q.sel;
  assign bus_addr_o  = bus_q.addr;
  assign bus_wdata_o = bus_q.wdata;

  // NOTE: every output of a combinational block is given a default first. This prevents latch inference.
  always_comb begin
    state_d     = state_q;
    bus_d       = bus_q;
    discard_d   = discard_q | (busy & flush_i);
    mem_rdata_d = data_ack ? rdata : mem_rdata_q;
    inst_d      = inst_ack ? rdata : inst_q;
    data_done_d = data_done_q | data_ack;
    inst_done_d = inst_done_q | inst_ack;

    unique case (state_q)
      IDLE: begin
        if (!flush_i && data_pend) begin
          state_d   = DATA;
          bus_d     = data_req;
          discard_d = 1'b0;
        end else if (!flush_i && inst_pend) begin
          state_d   = INST;
          bus_d     = inst_req;
          discard_d = 1'b0;
        end
      end
      DATA: begin
        if (ack) begin
          discard_d = 1'b0;
          if (!discard && inst_pend) begin
            state_d = INST;
            bus_d   = inst_req;
          end else begin
            state_d = IDLE;
            bus_d   = '0;
          end
        end
      end
      INST: begin
        if (ack) begin
          state_d   = IDLE;
          bus_d     = '0;
          discard_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        bus_d   = '0;
      end
    endcase

    // The pipeline advances whenever the stall is low, so the served requests retire.
    if (flush_i || !stallreq_o) begin
      data_done_d = 1'b0;
      inst_done_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. The reset is synchronous, so it is sampled inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_q       <= '0;
      data_done_q <= 1'b0;
      inst_done_q <= 1'b0;
      discard_q   <= 1'b0;
      mem_rdata_q <= 32'h0;
      inst_q      <= 32'h0;
    end else begin
      state_q     <= state_d;
      bus_q       <= bus_d;
      data_done_q <= data_done_d;
      inst_done_q <= inst_done_d;
      discard_q   <= discard_d;
      mem_rdata_q <= mem_rdata_d;
      inst_q      <= inst_d;
    end
  end

`ifdef MEMARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign timeout   = busy & ~bus_ack_i & (cnt_q == 8'(TIMEOUT));
  assign bus_err_o = timeout;

  // The count restarts whenever a new bus cycle begins, including DATA->INST chaining.
  always_comb begin
    cnt_d = 8'h0;
    if (busy && state_d == state_q) cnt_d = cnt_q + 8'h1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'h0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout   = 1'b0;
  assign bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter. The bus slave is driven cycle by cycle from the stimulus.
module tb_mem_bus_arbiter;
  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_inst_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        stallreq_o;
  logic        bus_cyc_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_o;

  int n_checks = 0;
  int n_errors = 0;
  int data_cyc = 0;

  mem_bus_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_inst_o(if_inst_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .stallreq_o(stallreq_o), .bus_cyc_o(bus_cyc_o), .bus_we_o(bus_we_o),
    .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge. Outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    if_ce_i = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'h0;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0; flush_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    if_addr_i = 32'h0; mem_addr_i = 32'h0; mem_data_i = 32'h0;
    idle_inputs();
    next_cycle();
    next_cycle();
    settle();
    check("rst_cyc",   bus_cyc_o,   32'h0);
    check("rst_stall", stallreq_o,  32'h0);
    check("rst_inst",  if_inst_o,   32'h0);
    check("rst_mdata", mem_data_o,  32'h0);
    check("rst_addr",  bus_addr_o,  32'h0);
    check("rst_sel",   bus_sel_o,   32'h0);
    check("rst_err",   bus_err_o,   32'h0);
    rst = 1'b0;
    next_cycle();

    // Fetch only, zero-wait slave.
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0100;
    settle();
    check("f_c0_stall", stallreq_o, 32'h1);
    check("f_c0_cyc",   bus_cyc_o,  32'h0);
    next_cycle();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h3408_1234;
    settle();
    check("f_c1_cyc",   bus_cyc_o,  32'h1);
    check("f_c1_addr",  bus_addr_o, 32'h0000_0100);
    check("f_c1_sel",   bus_sel_o,  32'hf);
    check("f_c1_we",    bus_we_o,   32'h0);
    check("f_c1_stall", stallreq_o, 32'h0);
    check("f_c1_inst",  if_inst_o,  32'h3408_1234);
    next_cycle();
    idle_inputs();
    settle();
    check("f_c2_cyc",   bus_cyc_o,  32'h0);
    check("f_c2_inst",  if_inst_o,  32'h3408_1234);
    check("f_c2_stall", stallreq_o, 32'h0);
    next_cycle();

    // Load and fetch in the same cycle. The two bus cycles are back-to-back.
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hf; mem_addr_i = 32'h0000_0040;
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0104;
    settle();
    check("lf_c0_stall", stallreq_o, 32'h1);
    next_cycle();
    bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_0001;
    settle();
    check("lf_c1_cyc",   bus_cyc_o,  32'h1);
    check("lf_c1_addr",  bus_addr_o, 32'h0000_0040);
    check("lf_c1_stall", stallreq_o, 32'h1);
    check("lf_c1_mdata", mem_data_o, 32'hCAFE_0001);
    next_cycle();
    bus_rdata_i = 32'h8C22_0000;
    settle();
    check("lf_c2_cyc",   bus_cyc_o,  32'h1);
    check("lf_c2_addr",  bus_addr_o, 32'h0000_0104);
    check("lf_c2_stall", stallreq_o, 32'h0);
    check("lf_c2_mdata", mem_data_o, 32'hCAFE_0001);
    check("lf_c2_inst",  if_inst_o,  32'h8C22_0000);
    next_cycle();
    idle_inputs();
    settle();
    check("lf_c3_cyc",   bus_cyc_o,  32'h0);
    check("lf_c3_mdata", mem_data_o, 32'hCAFE_0001);
    next_cycle();

    // Store with 3 wait states. The bus outputs must hold until the ack.
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
    mem_addr_i = 32'h0000_0080; mem_data_i = 32'hDEAD_BEEF;
    settle();
    check("st_c0_stall", stallreq_o, 32'h1);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      bus_ack_i = (i == 3);
      settle();
      check("st_cyc",   bus_cyc_o,   32'h1);
      check("st_we",    bus_we_o,    32'h1);
      check("st_sel",   bus_sel_o,   32'h3);
      check("st_addr",  bus_addr_o,  32'h0000_0080);
      check("st_wdata", bus_wdata_o, 32'hDEAD_BEEF);
      check("st_stall", stallreq_o,  (i == 3) ? 32'h0 : 32'h1);
      next_cycle();
    end
    idle_inputs();
    settle();
    check("st_end_cyc", bus_cyc_o, 32'h0);
    next_cycle();

    // Load acked while the fetch is pending. The fetch then waits 2 cycles.
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hf; mem_addr_i = 32'h0000_0044;
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0108;
    settle();
    next_cycle();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
    settle();
    if (bus_cyc_o && bus_addr_o == 32'h0000_0044) data_cyc++;
    check("lw_c1_addr", bus_addr_o, 32'h0000_0044);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      bus_ack_i = (i == 2); bus_rdata_i = (i == 2) ? 32'h3333_4444 : 32'h0;
      settle();
      if (bus_cyc_o && bus_addr_o == 32'h0000_0044) data_cyc++;
      check("lw_if_addr", bus_addr_o, 32'h0000_0108);
      check("lw_mdata",   mem_data_o, 32'h1111_2222);
      check("lw_stall",   stallreq_o, (i == 2) ? 32'h0 : 32'h1);
      next_cycle();
    end
    check("lw_data_cycles", 32'(data_cyc), 32'h1);
    idle_inputs();
    settle();
    check("lw_end_cyc",  bus_cyc_o, 32'h0);
    check("lw_end_inst", if_inst_o, 32'h3333_4444);
    next_cycle();

    // A flush while the fetch is waiting. The late ack is consumed and the fetch is reissued.
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0200;
    settle();
    next_cycle();
    flush_i = 1'b1;
    settle();
    check("fl_c1_cyc",   bus_cyc_o,  32'h1);
    check("fl_c1_stall", stallreq_o, 32'h0);
    next_cycle();
    flush_i = 1'b0;
    settle();
    check("fl_c2_cyc",   bus_cyc_o,  32'h1);
    check("fl_c2_stall", stallreq_o, 32'h1);
    next_cycle();
    bus_ack_i = 1'b1; bus_rdata_i = 32'hBADB_AD00;
    settle();
    next_cycle();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    settle();
    check("fl_c4_cyc",   bus_cyc_o,  32'h0);
    check("fl_c4_stall", stallreq_o, 32'h1);
    next_cycle();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h2402_0005;
    settle();
    check("fl_c5_cyc",   bus_cyc_o,  32'h1);
    check("fl_c5_addr",  bus_addr_o, 32'h0000_0200);
    check("fl_c5_inst",  if_inst_o,  32'h2402_0005);
    check("fl_c5_stall", stallreq_o, 32'h0);
    next_cycle();
    idle_inputs();
    settle();
    check("fl_c6_inst", if_inst_o, 32'h2402_0005);
    next_cycle();

    // Reset during a bus cycle. A late ack in IDLE is ignored.
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0300;
    settle();
    next_cycle();
    rst = 1'b1;
    settle();
    check("rs_c1_cyc",   bus_cyc_o,  32'h1);
    check("rs_c1_stall", stallreq_o, 32'h0);
    next_cycle();
    rst = 1'b0; if_ce_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    settle();
    check("rs_c2_cyc",  bus_cyc_o, 32'h0);
    check("rs_c2_inst", if_inst_o, 32'h0);
    next_cycle();
    idle_inputs();
    settle();
    check("rs_c3_cyc",  bus_cyc_o, 32'h0);
    check("rs_c3_inst", if_inst_o, 32'h0);
    next_cycle();

    // Unacknowledged fetch.
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0400; bus_rdata_i = 32'hAAAA_AAAA;
    settle();
    next_cycle();
`ifdef MEMARB_TIMEOUT_EN
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      settle();
      check("to_wait_err",   bus_err_o,  32'h0);
      check("to_wait_stall", stallreq_o, 32'h1);
      next_cycle();
    end
    settle();
    check("to_err",   bus_err_o,  32'h1);
    check("to_stall", stallreq_o, 32'h0);
    check("to_inst",  if_inst_o,  32'h0);
    next_cycle();
    idle_inputs();
    settle();
    check("to_end_cyc",  bus_cyc_o, 32'h0);
    check("to_end_err",  bus_err_o, 32'h0);
    check("to_end_inst", if_inst_o, 32'h0);
    next_cycle();
`else
    for (int i = 0; i < 6; i++) begin
      settle();
      check("nw_cyc",   bus_cyc_o,  32'h1);
      check("nw_err",   bus_err_o,  32'h0);
      check("nw_stall", stallreq_o, 32'h1);
      next_cycle();
    end
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0055;
    settle();
    check("nw_ack_stall", stallreq_o, 32'h0);
    check("nw_ack_inst",  if_inst_o,  32'h0000_0055);
    next_cycle();
    idle_inputs();
    settle();
    check("nw_end_cyc", bus_cyc_o, 32'h0);
    next_cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Single-port bus arbiter and sequencer that shares one external memory bus between the instruction-fetch port and the data-access port of the MIPS32 pipeline. It sits between the IF/MEM stages and the bus master interface. It converts each stage's combinational `ce` request into a registered, acknowledged bus cycle. It raises one stall request to `ctrl` until every request pending in the current pipeline cycle has been served.

## Interface
- TIMEOUT, 255: bus-cycle watchdog limit in clock cycles; used only when the watchdog is compiled in.
- clk  in  1  clock, all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush_i  in  1  pipeline flush; the result of any in-flight cycle is discarded.
- if_ce_i  in  1  instruction fetch request.
- if_addr_i  in  32  fetch address.
- if_inst_o  out  32  fetched instruction.
- mem_ce_i  in  1  data access request.
- mem_we_i  in  1  1 = write.
- mem_sel_i  in  4  byte enables.
- mem_addr_i  in  32  data address.
- mem_data_i  in  32  store data.
- mem_data_o  out  32  load data.
- stallreq_o  out  1  stall request to `ctrl`.
- bus_cyc_o  out  1  bus cycle active.
- bus_we_o  out  1  bus write enable.
- bus_sel_o  out  4  bus byte enables.
- bus_addr_o  out  32  bus address.
- bus_wdata_o  out  32  bus write data.
- bus_rdata_i  in  32  bus read data.
- bus_ack_i  in  1  bus cycle complete.
- bus_err_o  out  1  watchdog abort pulse.

## Operation
- FSM states: IDLE, DATA, INST.
- Priority: data over instruction, because the MEM-stage instruction is older.
- IDLE transitions:
  - mem_ce_i & ~data_done → DATA.
  - else if_ce_i & ~inst_done → INST.
  - else stay in IDLE.
- On entering a state, the bus outputs are registered from the request and held until the ack.
  - DATA: bus_we_o = mem_we_i, bus_sel_o = mem_sel_i, bus_addr_o = mem_addr_i, bus_wdata_o = mem_data_i.
  - INST: bus_we_o = 0, bus_sel_o = 4'b1111, bus_addr_o = if_addr_i, bus_wdata_o = 0.
- DATA + bus_ack_i:
  - Set data_done.
  - Capture bus_rdata_i into the data read register.
  - Next state is INST if (if_ce_i & ~inst_done), else IDLE.
- INST + bus_ack_i:
  - Set inst_done.
  - Capture bus_rdata_i into the instruction register.
  - Next state is IDLE.
- stallreq_o (combinational) = (mem_ce_i & ~data_done & ~(DATA & bus_ack_i)) | (if_ce_i & ~inst_done & ~(INST & bus_ack_i)).
- mem_data_o / if_inst_o:
  - Equal bus_rdata_i during their own ack cycle.
  - Otherwise equal the captured register value.
- data_done and inst_done clear on any edge where stallreq_o = 0, i.e. when the pipeline advances.
- Flush:
  - flush_i clears both done flags.
  - An in-flight cycle continues until its ack; that ack does not set a done flag, and the FSM returns to IDLE.
  - stallreq_o is forced to 0 while flush_i = 1.
- Reset values:
  - State = IDLE.
  - Done flags = 0.
  - All bus_* outputs = 0, mem_data_o = 0, if_inst_o = 0.
  - stallreq_o = 0 and bus_err_o = 0.
- rst asserted mid-cycle:
  - bus_cyc_o drops on the next edge.
  - A late ack arriving in IDLE is ignored.

## Timing
- A request seen in IDLE in cycle 0 produces bus_cyc_o = 1 in cycle 1.
- With a zero-wait slave, the ack arrives in cycle 1 and stallreq_o drops in cycle 1.
- Minimum cost is 1 stall cycle per access.
- Load + fetch in the same cycle, zero-wait slave:
  - DATA occupies cycle 1 and INST occupies cycle 2.
  - stallreq_o is high in cycles 0–1 and low in cycle 2.
  - No IDLE gap between the two cycles.
- bus_cyc_o deasserts for exactly 1 cycle between back-to-back transactions that both return through IDLE.
- All bus outputs are stable for the whole cycle while bus_cyc_o = 1.

## Configuration
- MEMARB_TIMEOUT_EN defined:
  - An 8-bit counter increments while in DATA or INST without an ack.
  - When it reaches TIMEOUT, the cycle is terminated as if acked, with read data forced to 0 and the done flag set.
  - bus_err_o pulses 1 for that one cycle.
  - The counter resets on each state entry.
- MEMARB_TIMEOUT_EN undefined:
  - The FSM waits for the ack indefinitely.
  - bus_err_o is tied to 0 and no counter exists.

## Test plan
- Fetch only, if_addr_i = 0x0000_0100, ack in the first bus cycle returning 0x3408_1234 → bus_cyc_o high for 1 cycle, if_inst_o = 0x3408_1234, stallreq_o high for 1 cycle.
- Load at 0x0000_0040 and fetch at 0x0000_0104 in the same cycle, zero-wait slave → addresses on the bus in order 0x40 then 0x104, back-to-back; stallreq_o high for 2 cycles; mem_data_o holds the data word until the pipeline advances.
- Store with mem_sel_i = 4'b0011 and data 0xDEAD_BEEF, slave acks after 3 wait cycles → bus_we_o = 1, bus_sel_o = 0011, bus_wdata_o = 0xDEAD_BEEF held for 4 cycles; stall released in the ack cycle.
- Load acked while the fetch is still pending and the slave stalls the fetch 2 cycles → the load is not reissued (exactly one DATA cycle seen on the bus).
- flush_i pulsed during a fetch waiting on ack → the ack is consumed, no done flag is set, the FSM returns to IDLE, and the next fetch is issued fresh.
- With MEMARB_TIMEOUT_EN and TIMEOUT = 4, no ack → bus_err_o pulses once after 4 cycles, if_inst_o = 0, and stallreq_o drops.
